// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl: 8-line prioritised interrupt controller with a CPU request and
// acknowledge handshake and a small register file.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-low; clears all state
//   irq_in     : [7:0] external interrupt lines, asynchronous to clk
//                (bit 0 is highest priority)
//   Ireq       : registered interrupt request to the CPU
//   Iack       : one-cycle acknowledge from the CPU
//   eret       : one-cycle pulse when ERET executes; ends service
//   IntCause   : [2:0] registered ID of the last acknowledged line
//   cfg_we     : register write strobe
//   cfg_addr   : [1:0] register address (0 MASK, 1 PENDING, 2 STATUS, 3 none)
//   cfg_wdata  : [31:0] register write data
//   cfg_rdata  : [31:0] combinational register read data
//
// Build option
//   IRQ_LEVEL_EN : when defined, pending follows the synchronised lines
//                  directly (level sensing); PENDING clears by W1C or by Iack
//                  have no effect. When undefined, rising edges are latched.
// -----------------------------------------------------------------------------
module irq_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  irq_in,
  output logic        Ireq,
  input  logic        Iack,
  input  logic        eret,
  output logic [2:0]  IntCause,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  // Index of the lowest set bit (highest priority line); 0 when none set.
  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  sync1_q, sync1_d;
  logic [7:0]  sync2_q, sync2_d;
  logic [7:0]  mask_q, mask_d;
  logic        gie_q, gie_d;
  logic        spur_q, spur_d;
  logic        ireq_q, ireq_d;
  logic [2:0]  cause_q, cause_d;
  logic [7:0]  pending_s;
  logic [7:0]  active_s;
  logic        qual_s;
  logic        wr_mask_s, wr_pend_s, wr_stat_s;
  logic        unused_s;

`ifndef IRQ_LEVEL_EN
  logic [7:0]  hist_q, hist_d;
  logic [7:0]  pend_q, pend_d;
  logic [7:0]  rise_s;
  logic [7:0]  ack_clr_s;
`endif

  assign unused_s = ^{cfg_wdata[30:10], cfg_wdata[8]};

  // Write strobe decode for the register file.
  always_comb begin
    wr_mask_s = cfg_we && (cfg_addr == 2'd0);
    wr_pend_s = cfg_we && (cfg_addr == 2'd1);
    wr_stat_s = cfg_we && (cfg_addr == 2'd2);
  end

  // Synchroniser chain; the history flop remembers the previous sync2 value.
  always_comb begin
    sync1_d = irq_in;
    sync2_d = sync1_q;
`ifndef IRQ_LEVEL_EN
    hist_d  = sync2_q;
`endif
  end

`ifndef IRQ_LEVEL_EN
  // Edge latching: a fresh rise always beats a W1C or acknowledge clear.
  always_comb begin
    rise_s = sync2_q & ~hist_q;
    if (wr_pend_s) begin
      pend_d = (pend_q & ~cfg_wdata[7:0] & ~ack_clr_s) | rise_s;
    end else begin
      pend_d = (pend_q & ~ack_clr_s) | rise_s;
    end
  end
  assign pending_s = pend_q;
`else
  assign pending_s = sync2_q;
`endif

  assign active_s = pending_s & mask_q;
  assign qual_s   = gie_q & (|active_s);

  // Request FSM next state; Ireq and IntCause are registered from here.
  always_comb begin
    state_d   = state_q;
    ireq_d    = ireq_q;
    cause_d   = cause_q;
`ifndef IRQ_LEVEL_EN
    ack_clr_s = 8'd0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (qual_s) begin
          state_d = ST_REQ;
          ireq_d  = 1'b1;
        end else begin
          ireq_d  = 1'b0;
        end
      end
      ST_REQ: begin
        if (!qual_s) begin
          // Request withdrawn before the CPU took it.
          state_d = ST_IDLE;
          ireq_d  = 1'b0;
        end else if (Iack) begin
          state_d   = ST_SERVICE;
          ireq_d    = 1'b0;
          cause_d   = lowest_idx(active_s);
`ifndef IRQ_LEVEL_EN
          ack_clr_s = 8'd1 << lowest_idx(active_s);
`endif
        end else begin
          ireq_d  = 1'b1;
        end
      end
      ST_SERVICE: begin
        ireq_d = 1'b0;
        if (eret) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SERVICE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ireq_d  = 1'b0;
      end
    endcase
  end

  // Configuration registers and the sticky spurious-acknowledge flag.
  always_comb begin
    if (wr_mask_s) begin
      mask_d = cfg_wdata[7:0];
      gie_d  = cfg_wdata[31];
    end else begin
      mask_d = mask_q;
      gie_d  = gie_q;
    end
    if (Iack && (state_q != ST_REQ)) begin
      spur_d = 1'b1;
    end else if (wr_stat_s && cfg_wdata[9]) begin
      spur_d = 1'b0;
    end else begin
      spur_d = spur_q;
    end
  end

  // All state flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sync1_q <= 8'd0;
      sync2_q <= 8'd0;
      mask_q  <= 8'd0;
      gie_q   <= 1'b0;
      spur_q  <= 1'b0;
      ireq_q  <= 1'b0;
      cause_q <= 3'd0;
`ifndef IRQ_LEVEL_EN
      hist_q  <= 8'd0;
      pend_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      mask_q  <= mask_d;
      gie_q   <= gie_d;
      spur_q  <= spur_d;
      ireq_q  <= ireq_d;
      cause_q <= cause_d;
`ifndef IRQ_LEVEL_EN
      hist_q  <= hist_d;
      pend_q  <= pend_d;
`endif
    end
  end

  assign Ireq     = ireq_q;
  assign IntCause = cause_q;

  // Register read mux; unmapped bits read 0.
  always_comb begin
    case (cfg_addr)
      2'd0:    cfg_rdata = {gie_q, 23'd0, mask_q};
      2'd1:    cfg_rdata = {24'd0, pending_s};
      2'd2:    cfg_rdata = {22'd0, spur_q, (state_q == ST_SERVICE), 5'd0, cause_q};
      default: cfg_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_in;
  logic        Ireq;
  logic        Iack;
  logic        eret;
  logic [2:0]  IntCause;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;

  irq_ctrl dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .Ireq(Ireq), .Iack(Iack),
    .eret(eret), .IntCause(IntCause), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0; cfg_wdata = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    cfg_addr = a;
    #1;
    chk(name, cfg_rdata, exp);
  endtask

  task automatic pulse_iack();
    Iack = 1'b1; tick(); Iack = 1'b0;
  endtask

  task automatic pulse_eret();
    eret = 1'b1; tick(); eret = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; irq_in = 8'd0; Iack = 1'b0; eret = 1'b0;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 32'd0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // ---------------- reference model (random phase) ----------------
  logic [7:0] m_samp[$];   // irq_in sampled at past edges, [0] newest
  logic [7:0] m_pend, m_mask;
  logic       m_gie, m_spur, m_ireq;
  logic [2:0] m_cause;
  int         m_phase;     // 0 idle, 1 requesting, 2 in service

  task automatic m_reset();
    m_samp = '{8'd0, 8'd0, 8'd0};
    m_pend = 8'd0; m_mask = 8'd0; m_gie = 1'b0; m_spur = 1'b0;
    m_ireq = 1'b0; m_cause = 3'd0; m_phase = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {m_gie, 23'd0, m_mask};
      2'd1:    return {24'd0, m_pend};
      2'd2:    return {22'd0, m_spur, (m_phase == 2), 5'd0, m_cause};
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge with the given inputs.
  task automatic m_edge(input logic [7:0] irq, input logic ack, input logic er,
                        input logic we, input logic [1:0] a, input logic [31:0] d);
    logic [7:0] rise, act, clr, w1c;
    logic       qual;
    int         low;
    rise = m_samp[1] & ~m_samp[2];
    act  = m_pend & m_mask;
    qual = m_gie && (act != 8'd0);
    low  = 0;
    for (int i = 7; i >= 0; i--) if (act[i]) low = i;
    clr = 8'd0;
    if (ack && m_phase != 1) m_spur = 1'b1;
    else if (we && a == 2'd2 && d[9]) m_spur = 1'b0;
    if (m_phase == 0) begin
      if (qual) begin m_phase = 1; m_ireq = 1'b1; end
    end else if (m_phase == 1) begin
      if (!qual) begin m_phase = 0; m_ireq = 1'b0; end
      else if (ack) begin
        m_cause = 3'(low); clr = 8'd1 << low; m_phase = 2; m_ireq = 1'b0;
      end
    end else begin
      m_ireq = 1'b0;
      if (er) m_phase = 0;
    end
    w1c = (we && a == 2'd1) ? d[7:0] : 8'd0;
    m_pend = (m_pend & ~w1c & ~clr) | rise;
    if (we && a == 2'd0) begin m_mask = d[7:0]; m_gie = d[31]; end
    m_samp.push_front(irq);
    void'(m_samp.pop_back());
`ifdef IRQ_LEVEL_EN
    m_pend = m_samp[1];
`endif
  endtask

  // ---------------- register table ----------------
  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b1, 2'd0, 32'h8000_00A5, 2'd0, 32'h8000_00A5};
    tbl[1] = '{1'b1, 2'd0, 32'h7FFF_FF3C, 2'd0, 32'h0000_003C};
    tbl[2] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 2'd3, 32'h0000_0000};
    tbl[3] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 2'd0, 32'h0000_003C};
    tbl[4] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 2'd1, 32'h0000_0000};
    tbl[5] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 2'd2, 32'h0000_0000};
    tbl[6] = '{1'b1, 2'd0, 32'hFFFF_FFFF, 2'd0, 32'h8000_00FF};
    tbl[7] = '{1'b0, 2'd0, 32'h0000_0000, 2'd0, 32'h8000_00FF};
    tbl[8] = '{1'b1, 2'd0, 32'h0000_0000, 2'd0, 32'h0000_0000};

    do_reset();
    reset = 1'b0;
    #1;
    chk("reset_ireq", {31'd0, Ireq}, 32'd0);
    chk("reset_cause", {29'd0, IntCause}, 32'd0);
    for (int a = 0; a < 4; a++) rd(2'(a), 32'd0, $sformatf("reset_reg%0d", a));
    reset = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].we) wr(tbl[i].addr, tbl[i].wdata);
      else tick();
      rd(tbl[i].raddr, tbl[i].exp, $sformatf("table%0d", i));
      chk($sformatf("table%0d_ireq", i), {31'd0, Ireq}, 32'd0);
    end

`ifndef IRQ_LEVEL_EN
    // Basic acknowledge path with exact edge latency.
    do_reset();
    wr(2'd0, 32'h8000_0001);
    irq_in = 8'h01;
    tick(); tick();
    rd(2'd1, 32'h00, "pend_edge2");
    tick();
    rd(2'd1, 32'h01, "pend_edge3");
    chk("ireq_edge3", {31'd0, Ireq}, 32'd0);
    tick();
    chk("ireq_edge4", {31'd0, Ireq}, 32'd1);
    pulse_iack();
    chk("ack_cause", {29'd0, IntCause}, 32'd0);
    chk("ack_ireq", {31'd0, Ireq}, 32'd0);
    rd(2'd1, 32'h00, "ack_pend");
    rd(2'd2, 32'h100, "ack_status");
    pulse_eret();
    tick();
    chk("eret_no_rearm", {31'd0, Ireq}, 32'd0);
    rd(2'd2, 32'h000, "eret_status");

    // Two simultaneous lines: priority order.
    do_reset();
    wr(2'd0, 32'h8000_0024);
    irq_in = 8'h24;
    tick(); tick(); tick(); tick();
    chk("two_ireq", {31'd0, Ireq}, 32'd1);
    pulse_iack();
    chk("two_cause1", {29'd0, IntCause}, 32'd2);
    rd(2'd1, 32'h20, "two_pend");
    pulse_eret();
    chk("two_eret_ireq0", {31'd0, Ireq}, 32'd0);
    tick();
    chk("two_ireq_again", {31'd0, Ireq}, 32'd1);
    pulse_iack();
    chk("two_cause2", {29'd0, IntCause}, 32'd5);

    // Request withdrawn by masking before Iack.
    do_reset();
    wr(2'd0, 32'h8000_0001);
    irq_in = 8'h01;
    tick(); tick(); tick(); tick();
    chk("wd_ireq", {31'd0, Ireq}, 32'd1);
    wr(2'd0, 32'h0000_0000);
    tick();
    chk("wd_ireq_drop", {31'd0, Ireq}, 32'd0);
    rd(2'd1, 32'h01, "wd_pend");
    rd(2'd2, 32'h000, "wd_status");
    wr(2'd0, 32'h8000_0001);
    tick();
    chk("wd_idle_rearm", {31'd0, Ireq}, 32'd1);

    // Spurious acknowledge.
    do_reset();
    pulse_iack();
    chk("spur_ireq", {31'd0, Ireq}, 32'd0);
    rd(2'd2, 32'h200, "spur_set");
    wr(2'd2, 32'h0000_0200);
    rd(2'd2, 32'h000, "spur_clr");

    // Rise and acknowledge clear on the same bit at the same edge.
    do_reset();
    wr(2'd0, 32'h8000_0001);
    irq_in = 8'h01; tick();
    irq_in = 8'h00; tick();
    irq_in = 8'h01; tick();
    tick();
    chk("race_ireq", {31'd0, Ireq}, 32'd1);
    pulse_iack();
    rd(2'd1, 32'h01, "race_set_wins");
    rd(2'd2, 32'h100, "race_status");

    // Reset in the middle of service.
    do_reset();
    wr(2'd0, 32'h8000_0001);
    irq_in = 8'h11;
    tick(); tick(); tick(); tick();
    pulse_iack();
    rd(2'd1, 32'h10, "mid_pend");
    rd(2'd2, 32'h100, "mid_status");
    reset = 1'b0;
    #1;
    chk("mid_rst_ireq", {31'd0, Ireq}, 32'd0);
    for (int a = 0; a < 4; a++) rd(2'(a), 32'd0, $sformatf("mid_rst_reg%0d", a));
    reset = 1'b1;
`else
    // Level sensing: source held across acknowledge and ERET.
    do_reset();
    wr(2'd0, 32'h8000_0008);
    irq_in = 8'h08;
    tick(); tick(); tick();
    chk("lvl_ireq", {31'd0, Ireq}, 32'd1);
    pulse_iack();
    chk("lvl_cause", {29'd0, IntCause}, 32'd3);
    rd(2'd1, 32'h08, "lvl_pend_ack");
    wr(2'd1, 32'h0000_0008);
    rd(2'd1, 32'h08, "lvl_w1c");
    pulse_eret();
    chk("lvl_eret_ireq0", {31'd0, Ireq}, 32'd0);
    tick();
    chk("lvl_rearm", {31'd0, Ireq}, 32'd1);
`endif

    // Randomised traffic against the reference model.
    do_reset();
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [7:0]  ri;
      logic        ra, re, rw;
      logic [1:0]  radr;
      logic [31:0] rdat;
      ri = irq_in;
      if ($urandom_range(0, 3) == 0) ri = ri ^ (8'd1 << $urandom_range(0, 7));
      ra   = ($urandom_range(0, 3) == 0);
      re   = ($urandom_range(0, 5) == 0);
      rw   = ($urandom_range(0, 9) == 0);
      radr = 2'($urandom_range(0, 3));
      rdat = $urandom;
      if (radr == 2'd0) rdat[31] = ($urandom_range(0, 7) != 0);
      irq_in = ri; Iack = ra; eret = re; cfg_we = rw; cfg_addr = radr; cfg_wdata = rdat;
      #2;
      chk("rnd_ireq", {31'd0, Ireq}, {31'd0, m_ireq});
      chk("rnd_cause", {29'd0, IntCause}, {29'd0, m_cause});
      chk($sformatf("rnd_rdata%0d", radr), cfg_rdata, m_read(radr));
      @(posedge clk);
      m_edge(ri, ra, re, rw, radr, rdat);
      #1;
    end
    cfg_we = 1'b0; Iack = 1'b0; eret = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
